ntt_ctrl: RTL and testbench
===========================

Name: ntt_ctrl

Overview:
Sequencer for the single butterfly_core datapath. It runs one full 7-layer Kyber forward NTT or inverse NTT over a 256-coefficient polynomial held in a dual-port RAM. Each cycle it issues one butterfly: a read address pair, a twiddle ROM index and the core mode. It tracks the butterfly results through the memory and core latency and generates the aligned write-back addresses. Between layers it drains the pipeline, so every layer reads fully written data.

Parameters:
RD_LAT, 1, read latency of the coefficient RAM and the twiddle ROM, in cycles.
BF_LAT, 5, butterfly_core latency in NTT/INTT mode, in cycles.
WR_DLY, RD_LAT+BF_LAT (6), cycles from issue to write-back. Derived, not overridable.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request pulse; sampled only in IDLE.
mode_in  in  2  0=NTT, 1=INTT; latched on an accepted start.
busy  out  1  high from the first issue cycle to the last write cycle.
done  out  1  one-cycle pulse after the final write-back.
err  out  1  one-cycle pulse when start arrives with mode_in of 2 or 3.
rd_en  out  1  RAM read strobe.
rd_addr_1  out  8  read address for operand j.
rd_addr_2  out  8  read address for operand j+len.
coef_addr  out  7  twiddle ROM index k; issued in the same cycle as rd_addr.
bf_mode  out  2  mode driven to butterfly_core; holds the latched mode.
wr_en  out  1  RAM write strobe for both ports.
wr_addr_1  out  8  write address for out_1.
wr_addr_2  out  8  write address for out_2.
layer  out  3  current layer 0..6, for debug and observation.

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM goes to IDLE.
  - The delay line is cleared, so pending writes are discarded.
  - A reset mid-transform aborts it with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start with mode_in 0 or 1: latch the mode and go to ISSUE with layer=0, b=0.
  - start with mode_in 2 or 3: pulse err and stay in IDLE.
  - start outside IDLE is ignored.
- ISSUE: one butterfly per cycle, b=0..127, with rd_en=1.
  - After b=127, go to DRAIN.
- DRAIN: lasts exactly WR_DLY cycles with rd_en=0.
  - At its end, if layer<6: increment layer, set b=0, go to ISSUE.
  - At its end, if layer=6: go to DONE.
- DONE: pulse done for one cycle and drop busy, then go to IDLE. bf_mode keeps its last value.
- Address generation, with s = log2(len):
  - NTT: len = 128>>layer.
  - INTT: len = 2<<layer.
  - j = {b[6:s], 1'b0, b[s-1:0]} (insert a 0 at bit s).
  - rd_addr_1 = j; rd_addr_2 = j | len.
  - Group index g = b>>s.
- Twiddle index:
  - NTT: k = 2^(7-s) + g.
  - INTT: k = 2^(8-s) - 1 - g.
  - k is always in 1..127; index 0 is never issued.
- Write-back:
  - A WR_DLY-deep shift register carries {valid, addr_1, addr_2}.
  - wr_en and wr_addr_* appear exactly WR_DLY cycles after the matching rd_en.
- Timing, with start sampled at cycle 0:
  - Layer L issues during cycles 1+134L .. 128+134L.
  - Writes occur during cycles 7+134L .. 134+134L.
  - Last write is at cycle 938; busy is high for cycles 1..938; done pulses at 939.
  - The next start is accepted at cycle 940 or later.
- Hazard rule: no read of layer L+1 occurs before the last write of layer L has committed. The RAM needs no write-through.

Decomposition:
- ntt_pkg holds:
  - Mode constants NTT=0, INTT=1, MULT=2, ADD_SUB=3, matching butterfly_core.
  - N=256, LAYERS=7, BFLY_PER_LAYER=128.
  - FSM state encoding.
- Sub-module ntt_addr_gen: combinational mapping from (mode, layer, b) to (rd_addr_1, rd_addr_2, coef_addr).
- The delay line and FSM stay in ntt_ctrl.

Test Plan:
- NTT start at cycle 0 -> cycle 1: rd (0,128), k=1. Cycle 128: rd (127,255), k=1. Cycle 7: wr (0,128).
- NTT layer 1 (cycle 135) -> b=0: (0,64), k=2. b=64: (128,192), k=3. Layer 6, b=127: (253,255), k=127.
- INTT -> layer 0, b=0: (0,2), k=127. b=127: (253,255), k=64. Layer 6, b=0: (0,128), k=1. done at cycle 939.
- Drain check -> rd_en=0 for cycles 129..134. wr_en=1 for cycles 7..134. First layer-1 read at cycle 135.
- start with mode_in=2 -> err pulses, busy stays 0. start re-pulsed at cycle 50 of a run -> ignored, sequence unchanged.
- rst_n low at cycle 300, released, then start -> outputs 0 during reset, no done pulse. The new run restarts at layer 0 with the cycle-1 addresses (0,128).

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants, FSM encoding and write-back record for the NTT sequencer.
package ntt_pkg;
    localparam logic [1:0] NTT     = 2'd0;
    localparam logic [1:0] INTT    = 2'd1;
    localparam logic [1:0] MULT    = 2'd2;
    localparam logic [1:0] ADD_SUB = 2'd3;

    localparam int N              = 256;
    localparam int LAYERS         = 7;
    localparam int BFLY_PER_LAYER = 128;

    localparam int AW = $clog2(N);
    localparam int BW = $clog2(BFLY_PER_LAYER);
    localparam int LW = $clog2(LAYERS);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

    typedef struct packed {
        logic          vld;
        logic [AW-1:0] addr_1;
        logic [AW-1:0] addr_2;
    } wb_t;
endpackage

// File: rtl/ntt_ctrl_if.sv
// Host/RAM-facing signal bundle of the NTT sequencer; master = host, slave = sequencer.
interface ntt_ctrl_if;
    import ntt_pkg::*;

    logic          start;
    logic [1:0]    mode_in;
    logic          busy;
    logic          done;
    logic          err;
    logic          rd_en;
    logic [AW-1:0] rd_addr_1;
    logic [AW-1:0] rd_addr_2;
    logic [BW-1:0] coef_addr;
    logic [1:0]    bf_mode;
    logic          wr_en;
    logic [AW-1:0] wr_addr_1;
    logic [AW-1:0] wr_addr_2;
    logic [LW-1:0] layer;

    modport master (
        output start, mode_in,
        input  busy, done, err, rd_en, rd_addr_1, rd_addr_2, coef_addr,
               bf_mode, wr_en, wr_addr_1, wr_addr_2, layer
    );

    modport slave (
        input  start, mode_in,
        output busy, done, err, rd_en, rd_addr_1, rd_addr_2, coef_addr,
               bf_mode, wr_en, wr_addr_1, wr_addr_2, layer
    );
endinterface

// File: rtl/ntt_addr_gen.sv
// Maps (mode, layer, butterfly index) to the operand pair and twiddle index.
// Purely combinational; no flow control.
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  logic [1:0]    mode,
    input  logic [LW-1:0] layer,
    input  logic [BW-1:0] b,
    output logic [AW-1:0] rd_addr_1,
    output logic [AW-1:0] rd_addr_2,
    output logic [BW-1:0] coef_addr
);
    logic [2:0]    s;
    logic [AW-1:0] len;
    logic [AW-1:0] lo_mask;
    logic [AW-1:0] b_ext;
    logic [AW-1:0] j;
    logic [BW-1:0] g;

    always_comb begin
        s       = (mode == INTT) ? 3'(layer + 3'd1) : 3'(3'd7 - layer);
        len     = AW'(1) << s;
        lo_mask = len - AW'(1);
        b_ext   = {1'b0, b};
        // Insert a zero at bit s: low bits stay, high bits move up by one.
        j       = (b_ext & lo_mask) | ((b_ext & ~lo_mask) << 1);
        g       = b >> s;
        rd_addr_1 = j;
        rd_addr_2 = j | len;
        // INTT base 2^(8-s)-1 is a run of (8-s) ones; s=1 yields all seven bits set.
        if (mode == INTT) begin
            coef_addr = ~({BW{1'b1}} << (4'd8 - {1'b0, s})) - g;
        end else begin
            coef_addr = (BW'(1) << (3'd7 - s)) + g;
        end
    end
endmodule

// File: rtl/ntt_ctrl.sv
// Issues one butterfly per cycle for a 7-layer NTT/INTT and realigns write-back
// addresses WR_DLY cycles later; drains between layers, accepts start only when idle.
module ntt_ctrl
    import ntt_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 5
)
(
    input  logic       clk,
    input  logic       rst_n,
    ntt_ctrl_if.slave  bus
);
    localparam int WR_DLY = RD_LAT + BF_LAT;
    localparam int DCW    = $clog2(WR_DLY + 1);

    state_t         state;
    logic [1:0]     mode_q;
    logic [LW-1:0]  layer_q;
    logic [BW-1:0]  b_q;
    logic [DCW-1:0] drain_cnt;
    logic           rd_en_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;

    logic [AW-1:0]  a1;
    logic [AW-1:0]  a2;
    logic [BW-1:0]  k;
    logic [AW-1:0]  rd_a1;
    logic [AW-1:0]  rd_a2;
    wb_t            dly [WR_DLY];

    ntt_addr_gen u_addr_gen (
        .mode      (mode_q),
        .layer     (layer_q),
        .b         (b_q),
        .rd_addr_1 (a1),
        .rd_addr_2 (a2),
        .coef_addr (k)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= NTT;
            layer_q   <= '0;
            b_q       <= '0;
            drain_cnt <= '0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.mode_in == MULT || bus.mode_in == ADD_SUB) begin
                            err_q <= 1'b1;
                        end else begin
                            state   <= ST_ISSUE;
                            mode_q  <= bus.mode_in;
                            layer_q <= '0;
                            b_q     <= '0;
                            rd_en_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (b_q == BW'(BFLY_PER_LAYER - 1)) begin
                        state     <= ST_DRAIN;
                        rd_en_q   <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        b_q <= b_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Wait until the last write of this layer has committed.
                    if (drain_cnt == DCW'(WR_DLY - 1)) begin
                        if (layer_q == LW'(LAYERS - 1)) begin
                            state  <= ST_DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ST_ISSUE;
                            layer_q <= layer_q + 1'b1;
                            b_q     <= '0;
                            rd_en_q <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_a1 = rd_en_q ? a1 : '0;
    assign rd_a2 = rd_en_q ? a2 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WR_DLY; i++) dly[i] <= '0;
        end else begin
            dly[0] <= '{vld: rd_en_q, addr_1: rd_a1, addr_2: rd_a2};
            for (int i = 1; i < WR_DLY; i++) dly[i] <= dly[i-1];
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_1 = rd_a1;
    assign bus.rd_addr_2 = rd_a2;
    assign bus.coef_addr = rd_en_q ? k : '0;
    assign bus.bf_mode   = mode_q;
    assign bus.wr_en     = dly[WR_DLY-1].vld;
    assign bus.wr_addr_1 = dly[WR_DLY-1].addr_1;
    assign bus.wr_addr_2 = dly[WR_DLY-1].addr_2;
    assign bus.layer     = layer_q;
endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: per-cycle comparison against a transform-level timing/address model.
module tb_ntt_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic [1:0] last_mode = 2'd0;

    ntt_ctrl_if bus();

    ntt_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Butterfly b of layer L from the Cooley-Tukey / Gentleman-Sande index rules.
    function automatic logic [22:0] bfly(input int m, input int L, input int b);
        int len, g, j, k;
        len = (m == 0) ? (128 >> L) : (2 << L);
        g   = b / len;
        j   = g * 2 * len + b % len;
        k   = (m == 0) ? (128 / len + g) : (256 / len - 1 - g);
        return {8'(j), 8'(j + len), 7'(k)};
    endfunction

    // Expected outputs t cycles after the start was sampled; layers are 134 cycles apart.
    function automatic logic [48:0] exp_vec(input int m, input int t);
        logic [48:0] e;
        logic [22:0] f;
        int tw;
        e = '0;
        if (t >= 1 && (t - 1) / 134 <= 6 && (t - 1) % 134 < 128) begin
            f = bfly(m, (t - 1) / 134, (t - 1) % 134);
            e[48]    = 1'b1;
            e[47:25] = f;
        end
        tw = t - 6;
        if (tw >= 1 && (tw - 1) / 134 <= 6 && (tw - 1) % 134 < 128) begin
            f = bfly(m, (tw - 1) / 134, (tw - 1) % 134);
            e[24]   = 1'b1;
            e[23:8] = f[22:7];
        end
        e[7]   = (t >= 1 && t <= 938);
        e[6]   = (t == 939);
        e[4:2] = (t <= 938) ? 3'((t - 1) / 134) : 3'd6;
        e[1:0] = 2'(m);
        return e;
    endfunction

    function automatic logic [48:0] raw_out();
        return {bus.rd_en, bus.rd_addr_1, bus.rd_addr_2, bus.coef_addr,
                bus.wr_en, bus.wr_addr_1, bus.wr_addr_2,
                bus.busy, bus.done, bus.err, bus.layer, bus.bf_mode};
    endfunction

    // Address fields are only meaningful while their strobe is expected high.
    function automatic logic [48:0] obs_vec(input logic [48:0] e);
        logic [48:0] o;
        o = raw_out();
        if (!e[48]) o[47:25] = '0;
        if (!e[24]) o[23:8]  = '0;
        return o;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.mode_in = 2'd0;
        tick();
        tick();
        checks++;
        if (raw_out() !== 49'd0) begin
            failures++;
            $display("FAIL reset got=%h exp=0", raw_out());
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_err();
        for (int md = 2; md <= 3; md++) begin
            bus.start = 1'b1;
            bus.mode_in = 2'(md);
            tick();
            bus.start = 1'b0;
            checks++;
            if ({bus.err, bus.busy, bus.rd_en, bus.done, bus.bf_mode} !== {4'b1000, last_mode}) begin
                failures++;
                $display("FAIL err_pulse mode=%0d got=%b exp=%b", md,
                         {bus.err, bus.busy, bus.rd_en, bus.done, bus.bf_mode}, {4'b1000, last_mode});
            end
            tick();
            checks++;
            if ({bus.err, bus.busy, bus.rd_en} !== 3'b000) begin
                failures++;
                $display("FAIL err_clear mode=%0d got=%b exp=000", md, {bus.err, bus.busy, bus.rd_en});
            end
        end
    endtask

    task automatic test_ntt();
        logic [48:0] e, o;
        logic [22:0] sp;
        bit has_sp;
        bus.start = 1'b1;
        bus.mode_in = 2'd0;
        last_mode = 2'd0;
        for (int t = 1; t <= 940; t++) begin
            tick();
            bus.start = 1'b0;
            bus.mode_in = 2'($urandom);
            e = exp_vec(0, t);
            o = obs_vec(e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL ntt t=%0d got=%h exp=%h", t, o, e);
            end
            has_sp = 1'b1;
            case (t)
                1:       sp = {8'd0,   8'd128, 7'd1};
                128:     sp = {8'd127, 8'd255, 7'd1};
                135:     sp = {8'd0,   8'd64,  7'd2};
                199:     sp = {8'd128, 8'd192, 7'd3};
                932:     sp = {8'd253, 8'd255, 7'd127};
                default: begin sp = '0; has_sp = 1'b0; end
            endcase
            if (has_sp) begin
                checks++;
                if ({bus.rd_addr_1, bus.rd_addr_2, bus.coef_addr} !== sp) begin
                    failures++;
                    $display("FAIL ntt_spot t=%0d got=%h exp=%h", t,
                             {bus.rd_addr_1, bus.rd_addr_2, bus.coef_addr}, sp);
                end
            end
            if (t == 7) begin
                checks++;
                if ({bus.wr_en, bus.wr_addr_1, bus.wr_addr_2} !== {1'b1, 8'd0, 8'd128}) begin
                    failures++;
                    $display("FAIL ntt_first_wr got=%h exp=%h",
                             {bus.wr_en, bus.wr_addr_1, bus.wr_addr_2}, {1'b1, 8'd0, 8'd128});
                end
            end
        end
    endtask

    task automatic test_intt();
        logic [48:0] e, o;
        logic [22:0] sp;
        bit has_sp;
        bus.start = 1'b1;
        bus.mode_in = 2'd1;
        last_mode = 2'd1;
        for (int t = 1; t <= 940; t++) begin
            tick();
            bus.start = 1'b0;
            bus.mode_in = 2'($urandom);
            if (t == 50) bus.start = 1'b1;
            e = exp_vec(1, t);
            o = obs_vec(e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL intt t=%0d got=%h exp=%h", t, o, e);
            end
            has_sp = 1'b1;
            case (t)
                1:       sp = {8'd0,   8'd2,   7'd127};
                128:     sp = {8'd253, 8'd255, 7'd64};
                805:     sp = {8'd0,   8'd128, 7'd1};
                default: begin sp = '0; has_sp = 1'b0; end
            endcase
            if (has_sp) begin
                checks++;
                if ({bus.rd_addr_1, bus.rd_addr_2, bus.coef_addr} !== sp) begin
                    failures++;
                    $display("FAIL intt_spot t=%0d got=%h exp=%h", t,
                             {bus.rd_addr_1, bus.rd_addr_2, bus.coef_addr}, sp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [48:0] e, o;
        int m, gt;
        for (int r = 0; r < 2; r++) begin
            m  = int'($urandom_range(0, 1));
            gt = int'($urandom_range(2, 939));
            bus.start = 1'b1;
            bus.mode_in = 2'(m);
            last_mode = 2'(m);
            for (int t = 1; t <= 940; t++) begin
                tick();
                bus.start = 1'b0;
                bus.mode_in = 2'($urandom);
                if (t == gt) bus.start = 1'b1;
                e = exp_vec(m, t);
                o = obs_vec(e);
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL b2b run=%0d mode=%0d t=%0d got=%h exp=%h", r, m, t, o, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [48:0] e, o;
        int m, cut;
        m   = int'($urandom_range(0, 1));
        cut = int'($urandom_range(200, 900));
        bus.start = 1'b1;
        bus.mode_in = 2'(m);
        for (int t = 1; t <= cut; t++) begin
            tick();
            bus.start = 1'b0;
            e = exp_vec(m, t);
            o = obs_vec(e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL pre_reset t=%0d got=%h exp=%h", t, o, e);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (raw_out() !== 49'd0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", raw_out());
        end
        tick();
        checks++;
        if (raw_out() !== 49'd0) begin
            failures++;
            $display("FAIL held_reset got=%h exp=0", raw_out());
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if ({bus.busy, bus.done, bus.wr_en, bus.rd_en} !== 4'b0000) begin
                failures++;
                $display("FAIL post_reset c=%0d got=%b exp=0000", c,
                         {bus.busy, bus.done, bus.wr_en, bus.rd_en});
            end
        end
        m = int'($urandom_range(0, 1));
        bus.start = 1'b1;
        bus.mode_in = 2'(m);
        last_mode = 2'(m);
        for (int t = 1; t <= 940; t++) begin
            tick();
            bus.start = 1'b0;
            bus.mode_in = 2'($urandom);
            e = exp_vec(m, t);
            o = obs_vec(e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL restart mode=%0d t=%0d got=%h exp=%h", m, t, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_err();
        test_ntt();
        test_intt();
        test_back_to_back();
        test_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
